// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter for the core's UART peripheral. A parallel word taken from
// the data register is sent as an asynchronous frame: one start bit (0), the
// payload LSB first, then STOP_BITS stop bits (1). The line idles high.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2), e.g. 50 MHz / 115200
//   DATA_BITS     payload bits per frame (5..9)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   tx_start  in   request to send; accepted only while no frame is in progress
//                  (or on the edge that ends the final stop bit)
//   tx_data   in   payload, captured on the accepting edge only
//   tx        out  serial line, idle 1
//   busy      out  high while a frame is in progress
//   done      out  one-cycle pulse after the final stop bit completes
//
// All outputs are registered, so tx only moves on a clock edge or on reset.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic                 stop_idx, stop_idx_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end;

  assign bit_end = (baud_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    stop_idx_n  = stop_idx;
    done_n      = 1'b0;

    // The baud counter free-runs through every bit of a frame and wraps on the
    // same edge that ends a bit, so each bit lasts exactly CLKS_PER_BIT cycles.
    if (state != IDLE) begin
      baud_cnt_n = bit_end ? '0 : baud_cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_reg_n = tx_data;
          baud_cnt_n  = '0;
          state_n     = START;
        end
      end

      START: begin
        if (bit_end) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_reg_n = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
            state_n    = STOP;
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_idx == LAST_STOP) begin
            done_n     = 1'b1;
            stop_idx_n = 1'b0;
            // A request seen on the frame's last edge starts the next frame
            // immediately, so back-to-back frames have no idle gap.
            if (tx_start) begin
              shift_reg_n = tx_data;
              state_n     = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the *next* state and registered, so the line
    // level for a bit appears on the very edge that enters that bit.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is a handful of flops, not a memory array, so
      // it is reset with the rest; a reset mid-frame then leaves no stale data.
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_idx  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
      stop_idx  <= stop_idx_n;
      tx        <= tx_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8. One DUT
// uses a single stop bit, a second uses two stop bits. Expected payloads are
// queued when a frame is requested; a line receiver decodes the serial output
// of the first DUT and pops the queue for each complete frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       tx, busy, done;
  logic       tx2, busy2, done2;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         rx_frames = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start2),
    .tx_data  (tx_data2),
    .tx       (tx2),
    .busy     (busy2),
    .done     (done2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level n cycles after the accepting edge (one stop bit).
  function automatic logic exp_tx(input logic [7:0] d, input int n);
    int b;
    b = n / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  // Line receiver: samples mid-bit on falling edges, abandons a frame on reset.
  initial begin : rx_model
    logic [9:0] bits;
    logic       aborted;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        bits    = '1;
        aborted = 1'b0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) bits[c / CPB] = tx;
        end
        if (aborted) begin
          wait (reset === 1'b1);
        end else if (exp_q.size() == 0) begin
          check("rx_unexpected_frame", {22'd0, bits}, 32'h0);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_start_bit", bits[0], 1'b0);
          check("rx_data", bits[8:1], exp_b);
          check("rx_stop_bit", bits[9], 1'b1);
          rx_frames++;
        end
      end
    end
  end

  // One frame on dut; optionally pulses tx_start with 8'hFF mid-frame.
  task automatic run_frame(input logic [7:0] d, input int inject_at);
    int d0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    exp_q.push_back(d);
    d0 = done_cnt;
    @(posedge clk);
    for (int n = 0; n <= 41; n++) begin
      @(negedge clk);
      if (n < 40) begin
        check($sformatf("frame_%0h_tx[%0d]", d, n), tx, exp_tx(d, n));
        check($sformatf("frame_%0h_busy[%0d]", d, n), busy, 1'b1);
        check($sformatf("frame_%0h_done[%0d]", d, n), done, 1'b0);
      end else if (n == 40) begin
        check($sformatf("frame_%0h_done_end", d), done, 1'b1);
        check($sformatf("frame_%0h_busy_end", d), busy, 1'b0);
        check($sformatf("frame_%0h_tx_end", d), tx, 1'b1);
      end else begin
        check($sformatf("frame_%0h_done_once", d), done, 1'b0);
      end
      if (n == 0) tx_start = 1'b0;
      if (n == inject_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      if (n == inject_at + 1) tx_start = 1'b0;
    end
    check($sformatf("frame_%0h_done_count", d), done_cnt - d0, 1);
  endtask

  initial begin : stimulus
    int d0;
    reset     = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    tx_start2 = 1'b0;
    tx_data2  = 8'h00;

    // Reset held: outputs at reset values while the clock runs.
    repeat (5) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_tx2", tx2, 1'b1);
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // Single frame.
    run_frame(8'hA5, -1);
    repeat (3) @(negedge clk);

    // Request while busy is ignored.
    run_frame(8'h3C, 10);
    repeat (3) @(negedge clk);

    // Back-to-back frames with tx_start held high.
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    d0 = done_cnt;
    @(posedge clk);
    for (int n = 0; n <= 81; n++) begin
      @(negedge clk);
      if (n < 80) begin
        check($sformatf("b2b_tx[%0d]", n), tx, exp_tx((n < 40) ? 8'h01 : 8'h80, n % 40));
        check($sformatf("b2b_busy[%0d]", n), busy, 1'b1);
        check($sformatf("b2b_done[%0d]", n), done, (n == 40) ? 1'b1 : 1'b0);
      end else if (n == 80) begin
        check("b2b_done_end", done, 1'b1);
        check("b2b_busy_end", busy, 1'b0);
      end else begin
        check("b2b_done_once", done, 1'b0);
      end
      if (n == 0) tx_data = 8'h80;
      if (n == 40) tx_start = 1'b0;
    end
    check("b2b_done_count", done_cnt - d0, 2);
    repeat (3) @(negedge clk);

    // Reset mid-frame: line returns high without a clock edge, no done.
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h00;
    d0 = done_cnt;
    @(posedge clk);
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      if (n == 0) tx_start = 1'b0;
    end
    check("pre_reset_tx", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", tx, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("in_reset_done", done, 1'b0);
    end
    reset = 1'b1;
    repeat (45) begin
      @(negedge clk);
      check("post_reset_tx", tx, 1'b1);
      check("post_reset_busy", busy, 1'b0);
      check("post_reset_done", done, 1'b0);
    end
    check("abandoned_done_count", done_cnt - d0, 0);
    run_frame(8'h5A, -1);
    repeat (3) @(negedge clk);

    // Two stop bits on dut2.
    @(negedge clk);
    tx_start2 = 1'b1;
    tx_data2  = 8'h00;
    @(posedge clk);
    for (int n = 0; n <= 45; n++) begin
      @(negedge clk);
      if (n == 0) tx_start2 = 1'b0;
      check($sformatf("stop2_tx[%0d]", n), tx2, (n < 36) ? 1'b0 : 1'b1);
      check($sformatf("stop2_busy[%0d]", n), busy2, (n < 44) ? 1'b1 : 1'b0);
      check($sformatf("stop2_done[%0d]", n), done2, (n == 44) ? 1'b1 : 1'b0);
    end

    // Drain the scoreboard (bounded).
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("rx_frame_count", rx_frames, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
